convo_fifo_feeder: RTL and testbench

- Write-side driver for the convolution line-buffer FIFO.
- On `start`, streams one feature map (`num_rows` × `row_len` pixels, row-major) from a synchronous-read feature-map RAM into the FIFO's `wen`/`in` port.
- Stalls on FIFO `full` without losing or duplicating pixels.
- Sits between the feature-map BRAM and the window-generating FIFO in the CNN datapath.

---
 rtl/convo_pkg.sv | 14 +
 rtl/feeder_skid_buf.sv | 38 +++
 rtl/convo_fifo_feeder.sv | 162 ++++++++++++++++
 tb/tb_convo_fifo_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/convo_pkg.sv
// Shared constants and state encoding for the convolution FIFO feeder.
package convo_pkg;

   localparam int CONVO_WIDTH        = 8;
   localparam int CONVO_ADDR_BIT     = 5;
   localparam int CONVO_MEM_ADDR_BIT = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/feeder_skid_buf.sv
// Two-entry pixel buffer between the RAM read pipeline and the FIFO write port.
module feeder_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_q, rd_q;
   logic [1:0]       cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= ~wr_q;
         end
         if (pop_i) rd_q <= ~rd_q;
         cnt_q <= cnt_q + 2'(push_i) - 2'(pop_i);
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/convo_fifo_feeder.sv
// Streams a row-major feature map from a synchronous-read RAM into the line-buffer FIFO.
// Define CONVO_FEEDER_ZERO_PAD_EN to wrap the map in a 1-pixel zero border.
module convo_fifo_feeder
   import convo_pkg::*;
#(
   parameter int WIDTH        = CONVO_WIDTH,
   parameter int ADDR_BIT     = CONVO_ADDR_BIT,
   parameter int MEM_ADDR_BIT = CONVO_MEM_ADDR_BIT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MEM_ADDR_BIT-1:0] base_addr,
   input  logic [ADDR_BIT-1:0]     row_len,
   input  logic [ADDR_BIT-1:0]     num_rows,
   output logic                    mem_ren,
   output logic [MEM_ADDR_BIT-1:0] mem_addr,
   input  logic [WIDTH-1:0]        mem_rdata,
   input  logic                    fifo_full,
   output logic                    fifo_wen,
   output logic [WIDTH-1:0]        fifo_in,
   output logic                    busy,
   output logic                    done,
   output logic [2*ADDR_BIT-1:0]   pix_cnt
);

`ifdef CONVO_FEEDER_ZERO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif
   localparam int            CW    = ADDR_BIT + 1;
   localparam logic [CW-1:0] PAD_W = PAD_EN ? CW'(2) : CW'(0);

   feeder_state_t           state_q, state_d;
   logic [MEM_ADDR_BIT-1:0] addr_q, addr_d;
   logic [CW-1:0]           row_q, row_d, col_q, col_d;
   logic [ADDR_BIT-1:0]     rl_q, rl_d, nr_q, nr_d;
   logic [2*ADDR_BIT-1:0]   pix_q, pix_d;
   logic                    done_q, done_d, infl_q, infl_d, pad_q, pad_d;

   logic                    idle, start_ok, zero_dim, border, last, rd_go, can_rd, wen;
   logic [ADDR_BIT-1:0]     rl_cur, nr_cur;
   logic [CW-1:0]           lim_c, lim_r, cur_row, cur_col;
   logic [MEM_ADDR_BIT-1:0] cur_addr;
   logic [1:0]              cnt, occ;
   logic [WIDTH-1:0]        head, push_data;

   // A border slot travels the same 1-cycle pipe as a RAM read so ordering is preserved.
   assign push_data = pad_q ? '0 : mem_rdata;
   assign wen       = (cnt != 2'd0) & ~fifo_full;

   feeder_skid_buf #(.WIDTH(WIDTH)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .push_i  (infl_q),
      .din_i   (push_data),
      .pop_i   (wen),
      .dout_o  (head),
      .count_o (cnt)
   );

   always_comb begin
      idle     = (state_q == IDLE);
      start_ok = idle & start;
      rl_cur   = idle ? row_len  : rl_q;
      nr_cur   = idle ? num_rows : nr_q;
      zero_dim = (rl_cur == '0) | (nr_cur == '0);
      lim_c    = CW'(rl_cur) + PAD_W;
      lim_r    = CW'(nr_cur) + PAD_W;
      cur_row  = idle ? '0 : row_q;
      cur_col  = idle ? '0 : col_q;
      cur_addr = idle ? base_addr : addr_q;
      border   = PAD_EN & ((cur_row == '0) | (cur_row == lim_r - CW'(1)) |
                           (cur_col == '0) | (cur_col == lim_c - CW'(1)));
      last     = (cur_row == lim_r - CW'(1)) & (cur_col == lim_c - CW'(1));
      occ      = {1'b0, infl_q} + cnt;
      can_rd   = (occ < 2'd2) | ((occ == 2'd2) & wen);
      // The first read goes out in the start cycle to reach the FIFO two cycles later.
      rd_go    = start_ok ? ~zero_dim : ((state_q == RUN) & can_rd);
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      row_d   = row_q;
      col_d   = col_q;
      rl_d    = rl_q;
      nr_d    = nr_q;
      pix_d   = pix_q + (2*ADDR_BIT)'(wen);
      done_d  = 1'b0;
      infl_d  = rd_go;
      pad_d   = rd_go & border;
      case (state_q)
         IDLE: begin
            if (start) begin
               rl_d   = row_len;
               nr_d   = num_rows;
               pix_d  = '0;
               addr_d = base_addr;
               row_d  = '0;
               col_d  = '0;
               done_d = zero_dim;
            end
         end
         RUN: ;
         DRAIN: begin
            if (~infl_q & ((cnt == 2'd0) | ((cnt == 2'd1) & wen))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rd_go) begin
         if (~border) addr_d = cur_addr + MEM_ADDR_BIT'(1);
         state_d = last ? DRAIN : RUN;
         if (cur_col == lim_c - CW'(1)) begin
            col_d = '0;
            row_d = cur_row + CW'(1);
         end else begin
            col_d = cur_col + CW'(1);
            row_d = cur_row;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
         rl_q    <= '0;
         nr_q    <= '0;
         pix_q   <= '0;
         done_q  <= 1'b0;
         infl_q  <= 1'b0;
         pad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         row_q   <= row_d;
         col_q   <= col_d;
         rl_q    <= rl_d;
         nr_q    <= nr_d;
         pix_q   <= pix_d;
         done_q  <= done_d;
         infl_q  <= infl_d;
         pad_q   <= pad_d;
      end
   end

   assign mem_ren  = rd_go & ~border;
   assign mem_addr = mem_ren ? cur_addr : '0;
   assign fifo_wen = wen;
   assign fifo_in  = head;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign pix_cnt  = pix_q;

endmodule

// File: tb/tb_convo_fifo_feeder.sv
// Randomized self-checking bench for convo_fifo_feeder against a queue-based reference model.
module tb_convo_fifo_feeder;

`ifdef CONVO_FEEDER_ZERO_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0, fifo_full = 1'b0;
   logic [9:0] base_addr = '0, mem_addr;
   logic [4:0] row_len = '0, num_rows = '0;
   logic       mem_ren, fifo_wen, busy, done;
   logic [7:0] mem_rdata = '0, fifo_in;
   logic [9:0] pix_cnt;

   convo_fifo_feeder dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .row_len(row_len), .num_rows(num_rows), .mem_ren(mem_ren), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .fifo_full(fifo_full), .fifo_wen(fifo_wen), .fifo_in(fifo_in),
      .busy(busy), .done(done), .pix_cnt(pix_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0] ram [1024];
   always @(posedge clk) if (mem_ren) mem_rdata <= ram[mem_addr];

   int checks = 0, errors = 0;
   int cyc = 0, start_cyc, first_wen_cyc, last_wen_cyc, done_cyc, done_cnt, done_pix;
   int nrd, nwr, occ_viol, full_wr, busy_seen;
   logic done_busy;
   logic [7:0] got[$], exp[$];
   logic [9:0] got_addr[$], exp_addr[$];

   always @(negedge clk) begin
      cyc++;
      if (start && !busy && !rst) start_cyc = cyc;
      if (mem_ren) begin got_addr.push_back(mem_addr); nrd++; end
      if (fifo_wen) begin
         got.push_back(fifo_in); nwr++;
         if (first_wen_cyc < 0) first_wen_cyc = cyc;
         last_wen_cyc = cyc;
      end
      if (fifo_wen && fifo_full) full_wr++;
      if (nrd - nwr > 2) occ_viol++;
      if (busy) busy_seen++;
      if (done) begin done_cnt++; done_cyc = cyc; done_pix = int'(pix_cnt); done_busy = busy; end
   end

   task automatic clear_mon();
      got.delete(); got_addr.delete();
      start_cyc = -1; first_wen_cyc = -1; last_wen_cyc = -1; done_cyc = -1;
      done_cnt = 0; done_pix = -1; done_busy = 1'b1;
      nrd = 0; nwr = 0; occ_viol = 0; full_wr = 0; busy_seen = 0;
   endtask

   // Reference: walk the (optionally padded) map row-major; interior pixels consume RAM addresses.
   task automatic build_exp(input logic [9:0] b, input int rl, input int nr);
      logic [9:0] a;
      int lr, lc;
      a = b;
      exp.delete(); exp_addr.delete();
      if (rl == 0 || nr == 0) return;
      lr = PAD ? nr + 2 : nr;
      lc = PAD ? rl + 2 : rl;
      for (int r = 0; r < lr; r++)
         for (int c = 0; c < lc; c++)
            if (PAD && (r == 0 || r == lr - 1 || c == 0 || c == lc - 1)) exp.push_back(8'h00);
            else begin exp.push_back(ram[a]); exp_addr.push_back(a); a = a + 10'd1; end
   endtask

   function automatic int seq_diffs();
      int d = (got.size() > exp.size()) ? got.size() - exp.size() : exp.size() - got.size();
      for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) d++;
      return d;
   endfunction

   function automatic int addr_diffs();
      int d = (got_addr.size() > exp_addr.size()) ? got_addr.size() - exp_addr.size()
                                                  : exp_addr.size() - got_addr.size();
      for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
         if (got_addr[i] !== exp_addr[i]) d++;
      return d;
   endfunction

   task automatic launch(input logic [9:0] b, input int rl, input int nr);
      @(posedge clk); #1;
      base_addr = b; row_len = 5'(rl); num_rows = 5'(nr); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 0: FIFO never full; 1: random full + ignored starts; 2: 5-cycle full after 3rd write
   task automatic wait_done(input int mode, input int limit);
      int n = 0, st = 0;
      while (done_cnt == 0 && n < limit) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (mode == 1) begin
            fifo_full = ($urandom_range(0, 2) == 0);
            if (busy && $urandom_range(0, 7) == 0) begin
               start = 1'b1; base_addr = 10'($urandom); row_len = 5'($urandom); num_rows = 5'($urandom);
            end
         end else if (mode == 2) begin
            if (got.size() >= 3 && st < 5) begin fifo_full = 1'b1; st++; end
            else fifo_full = 1'b0;
         end else fifo_full = 1'b0;
         n++;
      end
      checks++;
      if (done_cnt == 0) begin errors++; $display("FAIL timeout: no done within %0d cycles", limit); end
      fifo_full = 1'b0; start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem_ren, fifo_wen, busy, done} !== 4'b0 || pix_cnt !== '0 || fifo_in !== '0 || mem_addr !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ren=%b wen=%b busy=%b done=%b pix=%0d in=%h addr=%h, want all 0",
                  mem_ren, fifo_wen, busy, done, pix_cnt, fifo_in, mem_addr);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      for (int a = 0; a < 1024; a++) ram[a] = a[7:0];
      clear_mon();
      build_exp(10'h010, 8, 4);
      launch(10'h010, 8, 4);
      wait_done(0, 500);
      checks++; if (seq_diffs() != 0) begin errors++; $display("FAIL basic_seq: %0d diffs, got %0d pixels want %0d", seq_diffs(), got.size(), exp.size()); end
      checks++; if (first_wen_cyc - start_cyc !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", first_wen_cyc - start_cyc); end
      checks++; if (last_wen_cyc - first_wen_cyc + 1 !== exp.size()) begin errors++; $display("FAIL basic_gapless: span %0d want %0d", last_wen_cyc - first_wen_cyc + 1, exp.size()); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
      checks++; if (done_pix !== exp.size()) begin errors++; $display("FAIL basic_pix_cnt: got %0d want %0d", done_pix, exp.size()); end
      checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", done_busy); end
      checks++; if (addr_diffs() != 0) begin errors++; $display("FAIL basic_addr: %0d diffs", addr_diffs()); end
   endtask

   task automatic test_stall();
      clear_mon();
      build_exp(10'h010, 8, 4);
      launch(10'h010, 8, 4);
      wait_done(2, 500);
      checks++; if (seq_diffs() != 0) begin errors++; $display("FAIL stall_seq: %0d diffs, got %0d pixels want %0d", seq_diffs(), got.size(), exp.size()); end
      checks++; if (full_wr !== 0) begin errors++; $display("FAIL stall_write_while_full: got %0d want 0", full_wr); end
      checks++; if (occ_viol !== 0) begin errors++; $display("FAIL stall_occupancy: %0d cycles over 2 outstanding, want 0", occ_viol); end
      checks++; if (last_wen_cyc - first_wen_cyc + 1 !== exp.size() + 5) begin errors++; $display("FAIL stall_span: got %0d want %0d", last_wen_cyc - first_wen_cyc + 1, exp.size() + 5); end
      checks++; if (nrd !== exp_addr.size()) begin errors++; $display("FAIL stall_reads: got %0d want %0d", nrd, exp_addr.size()); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); end
   endtask

   task automatic test_zero();
      int rls[2] = '{0, 3};
      int nrs[2] = '{4, 0};
      for (int k = 0; k < 2; k++) begin
         clear_mon();
         launch(10'h055, rls[k], nrs[k]);
         wait_done(0, 20);
         checks++; if (done_cyc - start_cyc !== 1) begin errors++; $display("FAIL zero%0d_done_latency: got %0d want 1", k, done_cyc - start_cyc); end
         checks++; if (nrd !== 0 || nwr !== 0) begin errors++; $display("FAIL zero%0d_activity: reads %0d writes %0d want 0/0", k, nrd, nwr); end
         checks++; if (busy_seen !== 0 || done_cnt !== 1) begin errors++; $display("FAIL zero%0d_busy_done: busy cycles %0d done %0d want 0/1", k, busy_seen, done_cnt); end
      end
   endtask

   task automatic test_wrap();
      logic [9:0] wa [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
      int bad = 0;
      for (int a = 0; a < 1024; a++) ram[a] = 8'($urandom);
      clear_mon();
      build_exp(10'h3FE, 4, 1);
      launch(10'h3FE, 4, 1);
      wait_done(0, 100);
      for (int i = 0; i < 4; i++) if (i >= got_addr.size() || got_addr[i] !== wa[i]) bad++;
      checks++; if (bad != 0 || got_addr.size() != 4) begin errors++; $display("FAIL wrap_addr: %0d bad of %0d reads, want 3FE,3FF,000,001", bad, got_addr.size()); end
      checks++; if (seq_diffs() != 0) begin errors++; $display("FAIL wrap_seq: %0d diffs, got %0d want %0d pixels", seq_diffs(), got.size(), exp.size()); end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      for (int a = 0; a < 1024; a++) ram[a] = a[7:0];
      clear_mon();
      launch(10'h010, 8, 4);
      while (nwr < 10 && n < 200) begin @(posedge clk); #1; n++; end
      checks++; if (nwr < 10) begin errors++; $display("FAIL rstmid_progress: got %0d writes want 10", nwr); end
      rst = 1'b1;
      #2;
      checks++;
      if (busy !== 1'b0 || fifo_wen !== 1'b0 || mem_ren !== 1'b0 || pix_cnt !== '0) begin
         errors++; $display("FAIL rstmid_outputs: busy=%b wen=%b ren=%b pix=%0d want 0", busy, fifo_wen, mem_ren, pix_cnt);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      build_exp(10'h080, 8, 4);
      launch(10'h080, 8, 4);
      checks++; if (pix_cnt !== '0) begin errors++; $display("FAIL rstmid_pix_start: got %0d want 0", pix_cnt); end
      wait_done(0, 500);
      checks++; if (got_addr.size() == 0 || got_addr[0] !== 10'h080) begin errors++; $display("FAIL rstmid_first_addr: got %h want 080", got_addr.size() ? got_addr[0] : 10'h3FF); end
      checks++; if (seq_diffs() != 0) begin errors++; $display("FAIL rstmid_seq: %0d diffs, got %0d want %0d pixels", seq_diffs(), got.size(), exp.size()); end
      checks++; if (done_pix !== exp.size()) begin errors++; $display("FAIL rstmid_pix_cnt: got %0d want %0d", done_pix, exp.size()); end
   endtask

   task automatic test_pad_example();
`ifdef CONVO_FEEDER_ZERO_PAD_EN
      logic [7:0] want [16] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0,
                                8'd0, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`else
      logic [7:0] want [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
`endif
      int bad = 0;
      for (int a = 0; a < 4; a++) ram[a] = 8'(a + 1);
      clear_mon();
      launch(10'h000, 2, 2);
      wait_done(0, 100);
      for (int i = 0; i < $size(want); i++) if (i >= got.size() || got[i] !== want[i]) bad++;
      checks++; if (bad != 0 || got.size() != $size(want)) begin errors++; $display("FAIL pad_example: %0d bad, got %0d pixels want %0d", bad, got.size(), $size(want)); end
      checks++; if (nrd !== 4) begin errors++; $display("FAIL pad_example_reads: got %0d want 4", nrd); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         logic [9:0] b = 10'($urandom);
         int rl = $urandom_range(1, 6), nr = $urandom_range(1, 5);
         for (int a = 0; a < 1024; a++) ram[a] = 8'($urandom);
         clear_mon();
         build_exp(b, rl, nr);
         launch(b, rl, nr);
         wait_done(1, 2000);
         checks++; if (seq_diffs() != 0) begin errors++; $display("FAIL rand%0d_seq: %0d diffs (%0dx%0d @%h)", it, seq_diffs(), rl, nr, b); end
         checks++; if (addr_diffs() != 0) begin errors++; $display("FAIL rand%0d_addr: %0d diffs", it, addr_diffs()); end
         checks++; if (done_cnt !== 1 || done_pix !== exp.size()) begin errors++; $display("FAIL rand%0d_done: done %0d pix %0d want 1/%0d", it, done_cnt, done_pix, exp.size()); end
         checks++; if (full_wr !== 0 || occ_viol !== 0) begin errors++; $display("FAIL rand%0d_flow: full writes %0d occupancy overruns %0d want 0/0", it, full_wr, occ_viol); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero();
      test_wrap();
      test_reset_mid();
      test_pad_example();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
